// File: rtl/lc3_pkg.sv
// Shared LC-3 core definitions: datapath widths and the instruction-fetch
// state encoding used by ifetch.
package lc3_pkg;

    localparam int LC3_ADDR_W = 16;
    localparam int LC3_INST_W = 16;

    // Fetch controller states.
    //   IF_IDLE : no transaction outstanding, waiting for run enable
    //   IF_REQ  : read request on the bus, waiting for the acknowledge
    //   IF_DROP : request still on the bus but its data has been flushed
    //   IF_HOLD : fetched word presented to decode, waiting for acceptance
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2,
        IF_HOLD = 2'd3
    } ifetch_state_t;

endpackage : lc3_pkg

// File: rtl/ifetch.sv
// Instruction fetch unit.
// Issues one instruction-memory read per fetch, hands the returned word to
// decode, and pulses pc_en_o_r once for every word actually delivered so the
// PC block can advance. A redirect (flush) discards the outstanding or held
// word; a request already on the bus is always completed before the unit
// returns to idle, since the memory protocol does not allow withdrawal.
module ifetch
    import lc3_pkg::*;
#(
    parameter int ADDR_W = LC3_ADDR_W,
    parameter int INST_W = LC3_INST_W
) (
    input  logic              clk_i_w,
    input  logic              rst_i_w,
    input  logic              fetch_en_i_w,
    input  logic [ADDR_W-1:0] pc_i_w,
    output logic              pc_en_o_r,
    input  logic              flush_i_w,
    output logic              mem_req_o_r,
    output logic [ADDR_W-1:0] mem_addr_o_r,
    input  logic              mem_ack_i_w,
    input  logic [INST_W-1:0] mem_rdata_i_w,
    output logic              inst_valid_o_r,
    output logic [INST_W-1:0] inst_o_r,
    output logic [ADDR_W-1:0] inst_pc_o_r,
    input  logic              inst_ready_i_w
);

    ifetch_state_t state_r;

    // Fetch FSM: all outputs are registered and updated together with the state.
    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            state_r        <= IF_IDLE;
            mem_req_o_r    <= 1'b0;
            mem_addr_o_r   <= '0;
            pc_en_o_r      <= 1'b0;
            inst_valid_o_r <= 1'b0;
            inst_o_r       <= '0;
            inst_pc_o_r    <= '0;
        end else begin
            // pc_en is a single-cycle strobe; only the REQ->HOLD hand-off raises it.
            pc_en_o_r <= 1'b0;

            case (state_r)
                IF_IDLE: begin
                    // The PC is only sampled here. The cycle in which pc_en is
                    // high is always spent in HOLD, so the advanced PC is what
                    // the next fetch picks up. A flush here blocks the start.
                    if (fetch_en_i_w && !flush_i_w) begin
                        mem_addr_o_r <= pc_i_w;
                        mem_req_o_r  <= 1'b1;
                        state_r      <= IF_REQ;
                    end
                end

                IF_REQ: begin
                    // Request and address stay untouched until the acknowledge.
                    if (mem_ack_i_w) begin
                        mem_req_o_r <= 1'b0;
                        if (flush_i_w) begin
                            // Data arrived together with a redirect: discard it.
                            state_r <= IF_IDLE;
                        end else begin
                            inst_o_r       <= mem_rdata_i_w;
                            inst_pc_o_r    <= mem_addr_o_r;
                            inst_valid_o_r <= 1'b1;
                            pc_en_o_r      <= 1'b1;
                            state_r        <= IF_HOLD;
                        end
                    end else if (flush_i_w) begin
                        // Cannot withdraw the request; remember to drop its data.
                        state_r <= IF_DROP;
                    end
                end

                IF_DROP: begin
                    // Wait out the stale transaction; further flushes change nothing.
                    if (mem_ack_i_w) begin
                        mem_req_o_r <= 1'b0;
                        state_r     <= IF_IDLE;
                    end
                end

                IF_HOLD: begin
                    // Word and its address are frozen while valid; flush wins over ready.
                    if (flush_i_w || inst_ready_i_w) begin
                        inst_valid_o_r <= 1'b0;
                        state_r        <= IF_IDLE;
                    end
                end

                default: begin
                    state_r <= IF_IDLE;
                end
            endcase
        end
    end

endmodule : ifetch

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch. Inputs change and outputs are sampled on the
// falling clock edge, so every observation reflects the preceding rising edge.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [15:0] pc;
    logic        pc_en;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        ack;
    logic [15:0] rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;
    int pc_en_cnt = 0;

    ifetch #(.ADDR_W(16), .INST_W(16)) dut (
        .clk_i_w        (clk),
        .rst_i_w        (rst),
        .fetch_en_i_w   (fetch_en),
        .pc_i_w         (pc),
        .pc_en_o_r      (pc_en),
        .flush_i_w      (flush),
        .mem_req_o_r    (mem_req),
        .mem_addr_o_r   (mem_addr),
        .mem_ack_i_w    (ack),
        .mem_rdata_i_w  (rdata),
        .inst_valid_o_r (inst_valid),
        .inst_o_r       (inst),
        .inst_pc_o_r    (inst_pc),
        .inst_ready_i_w (ready)
    );

    always #5 clk = ~clk;

    // Count PC-advance pulses as the PC block would see them.
    always @(posedge clk) begin
        if (pc_en === 1'b1) pc_en_cnt <= pc_en_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; pc = 16'h0000; flush = 1'b0;
        ack = 1'b0; rdata = 16'h0000; ready = 1'b0;
        step(); step();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr got=%h want=0000", mem_addr); end
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL reset_pc_en got=%b want=0", pc_en); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
        n_cmp++; if (inst !== 16'h0000) begin n_err++; $display("FAIL reset_inst got=%h want=0000", inst); end
        n_cmp++; if (inst_pc !== 16'h0000) begin n_err++; $display("FAIL reset_inst_pc got=%h want=0000", inst_pc); end
        rst = 1'b0;
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_en got=%b want=0", mem_req); end
    endtask

    task automatic test_basic();
        int c0;
        c0 = pc_en_cnt;
        fetch_en = 1'b1; pc = 16'h3000; ready = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL basic_req got=%b want=1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h3000) begin n_err++; $display("FAIL basic_addr got=%h want=3000", mem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%b want=0", inst_valid); end
        ack = 1'b1; rdata = 16'h1261;
        step();
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b want=1", inst_valid); end
        n_cmp++; if (inst !== 16'h1261) begin n_err++; $display("FAIL basic_inst got=%h want=1261", inst); end
        n_cmp++; if (inst_pc !== 16'h3000) begin n_err++; $display("FAIL basic_inst_pc got=%h want=3000", inst_pc); end
        n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL basic_pc_en got=%b want=1", pc_en); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop got=%b want=0", mem_req); end
        ack = 1'b0; rdata = 16'h0000; fetch_en = 1'b0;
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_clr got=%b want=0", inst_valid); end
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL basic_pc_en_clr got=%b want=0", pc_en); end
        n_cmp++; if (pc_en_cnt - c0 !== 1) begin n_err++; $display("FAIL basic_pc_en_count got=%0d want=1", pc_en_cnt - c0); end
    endtask

    task automatic test_wait();
        fetch_en = 1'b1; pc = 16'h3000; ready = 1'b1;
        step();
        pc = 16'h3100;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d] got=%b want=1", i, mem_req); end
            n_cmp++; if (mem_addr !== 16'h3000) begin n_err++; $display("FAIL wait_addr[%0d] got=%h want=3000", i, mem_addr); end
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d] got=%b want=0", i, inst_valid); end
            if (i == 4) begin ack = 1'b1; rdata = 16'h5A5A; end
            step();
        end
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid got=%b want=1", inst_valid); end
        n_cmp++; if (inst !== 16'h5A5A) begin n_err++; $display("FAIL wait_inst got=%h want=5a5a", inst); end
        n_cmp++; if (inst_pc !== 16'h3000) begin n_err++; $display("FAIL wait_inst_pc got=%h want=3000", inst_pc); end
        ack = 1'b0; fetch_en = 1'b0;
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid_clr got=%b want=0", inst_valid); end
    endtask

    task automatic test_drop();
        int c0;
        c0 = pc_en_cnt;
        fetch_en = 1'b1; pc = 16'h3002; ready = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drop_req0 got=%b want=1", mem_req); end
        step();
        flush = 1'b1; pc = 16'h4000;
        step();
        flush = 1'b0;
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drop_req1 got=%b want=1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h3002) begin n_err++; $display("FAIL drop_addr got=%h want=3002", mem_addr); end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drop_req2 got=%b want=1", mem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid0 got=%b want=0", inst_valid); end
        ack = 1'b1; rdata = 16'hDEAD;
        step();
        ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL drop_req_clr got=%b want=0", mem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid1 got=%b want=0", inst_valid); end
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL drop_pc_en got=%b want=0", pc_en); end
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drop_refetch_req got=%b want=1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h4000) begin n_err++; $display("FAIL drop_refetch_addr got=%h want=4000", mem_addr); end
        n_cmp++; if (pc_en_cnt !== c0) begin n_err++; $display("FAIL drop_pc_en_count got=%0d want=%0d", pc_en_cnt, c0); end
        ack = 1'b1; rdata = 16'h1234;
        step();
        n_cmp++; if (inst !== 16'h1234 || inst_pc !== 16'h4000 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL drop_refetch_inst got=%h@%h v=%b want=1234@4000 v=1", inst, inst_pc, inst_valid);
        end
        ack = 1'b0; fetch_en = 1'b0;
        step();
    endtask

    task automatic test_flush_ack();
        int c0;
        c0 = pc_en_cnt;
        fetch_en = 1'b1; pc = 16'h7000; ready = 1'b1;
        step();
        ack = 1'b1; flush = 1'b1; rdata = 16'hBEEF;
        step();
        ack = 1'b0; flush = 1'b0; fetch_en = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL flush_ack_req got=%b want=0", mem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL flush_ack_valid got=%b want=0", inst_valid); end
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL flush_ack_pc_en got=%b want=0", pc_en); end
        step();
        fetch_en = 1'b1; pc = 16'h7100;
        step();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h7100) begin
            n_err++; $display("FAIL flush_ack_idle req=%b addr=%h want req=1 addr=7100", mem_req, mem_addr);
        end
        n_cmp++; if (pc_en_cnt !== c0) begin n_err++; $display("FAIL flush_ack_count got=%0d want=%0d", pc_en_cnt, c0); end
        ack = 1'b1; rdata = 16'h0F0F;
        step();
        ack = 1'b0; fetch_en = 1'b0;
        step();
    endtask

    task automatic test_hold();
        int c0;
        c0 = pc_en_cnt;
        fetch_en = 1'b1; pc = 16'h5000; ready = 1'b0;
        step();
        ack = 1'b1; rdata = 16'hABCD;
        step();
        ack = 1'b0; rdata = 16'h0000; pc = 16'h5001;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got=%b want=1", i, inst_valid); end
            n_cmp++; if (inst !== 16'hABCD) begin n_err++; $display("FAIL hold_inst[%0d] got=%h want=abcd", i, inst); end
            n_cmp++; if (inst_pc !== 16'h5000) begin n_err++; $display("FAIL hold_inst_pc[%0d] got=%h want=5000", i, inst_pc); end
            n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] got=%b want=0", i, mem_req); end
            step();
        end
        flush = 1'b1; ready = 1'b1; fetch_en = 1'b0;
        step();
        flush = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL hold_flush_valid got=%b want=0", inst_valid); end
        n_cmp++; if (pc_en_cnt - c0 !== 1) begin n_err++; $display("FAIL hold_pc_en_count got=%0d want=1", pc_en_cnt - c0); end
        fetch_en = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_flush_block got=%b want=0", mem_req); end
        step();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h5001) begin
            n_err++; $display("FAIL idle_after_flush req=%b addr=%h want req=1 addr=5001", mem_req, mem_addr);
        end
        ack = 1'b1; rdata = 16'h2222;
        step();
        ack = 1'b0; fetch_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_req();
        int c0;
        c0 = pc_en_cnt;
        fetch_en = 1'b1; pc = 16'h6000; ready = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_pre got=%b want=1", mem_req); end
        rst = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_req got=%b want=0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_mid_addr got=%h want=0000", mem_addr); end
        rst = 1'b0; fetch_en = 1'b0; ack = 1'b1; rdata = 16'h3333;
        step();
        ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_late_ack_valid got=%b want=0", inst_valid); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_late_ack_req got=%b want=0", mem_req); end
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_late_valid2 got=%b want=0", inst_valid); end
        n_cmp++; if (pc_en_cnt !== c0) begin n_err++; $display("FAIL rst_pc_en_count got=%0d want=%0d", pc_en_cnt, c0); end
    endtask

    task automatic test_wrap();
        fetch_en = 1'b1; pc = 16'hFFFF; ready = 1'b1;
        step();
        n_cmp++; if (mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr0 got=%h want=ffff", mem_addr); end
        ack = 1'b1; rdata = 16'h1111;
        step();
        ack = 1'b0;
        n_cmp++; if (inst_pc !== 16'hFFFF || pc_en !== 1'b1) begin
            n_err++; $display("FAIL wrap_deliver inst_pc=%h pc_en=%b want ffff/1", inst_pc, pc_en);
        end
        pc = pc + 16'h0001;
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL wrap_idle_req got=%b want=0", mem_req); end
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req got=%b want=1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr1 got=%h want=0000", mem_addr); end
        ack = 1'b1; rdata = 16'h4444;
        step();
        ack = 1'b0; fetch_en = 1'b0;
        n_cmp++; if (inst !== 16'h4444 || inst_pc !== 16'h0000) begin
            n_err++; $display("FAIL wrap_inst got=%h@%h want=4444@0000", inst, inst_pc);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_drop();
        test_flush_ack();
        test_hold();
        test_reset_mid_req();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ifetch
